// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo: in-order store buffer with byte-masked stores, head drain and youngest-match forwarding.
// Define STORE_BUFFER_COALESCE_EN to merge stores into an existing entry with the same address.
module store_buffer_fifo #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 4,
    parameter int DRAIN_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [DATA_W/8-1:0]        st_be,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [DATA_W/8-1:0]        ld_be,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_conflict,
    output logic                       drain_valid,
    input  logic                       drain_ready,
    output logic [ADDR_W-1:0]          drain_addr,
    output logic [DATA_W-1:0]          drain_data,
    output logic [DATA_W/8-1:0]        drain_be,
    input  logic                       flush,
    output logic                       flush_done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {S_NORMAL = 1'b0, S_FLUSH = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push_s, pop_s, alloc_s;
    logic              fwd_found_s, fwd_m_s;
    logic [PTR_W-1:0]  fwd_idx_s;
    logic [PTR_W:0]    fwd_sum_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) r = '0;
        else                        r = p + PTR_W'(1);
        return r;
    endfunction

`ifdef STORE_BUFFER_COALESCE_EN
    logic              merge_s, st_match_s;
    logic [PTR_W-1:0]  st_match_idx_s;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_d,
                                                      input logic [DATA_W-1:0] new_d,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        for (int b = 0; b < BE_W; b++) begin
            r[8*b +: 8] = be[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
        end
        return r;
    endfunction

    // Locate the (unique) entry already holding the store address.
    always_comb begin
        st_match_s     = 1'b0;
        st_match_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            st_match_idx_s = (valid_q[i] && (addr_q[i] == st_addr)) ? PTR_W'(i) : st_match_idx_s;
            st_match_s     = st_match_s | (valid_q[i] && (addr_q[i] == st_addr));
        end
    end

    // A head being popped this cycle cannot absorb the store; it allocates instead.
    assign merge_s  = push_s && st_match_s && !(pop_s && (st_match_idx_s == head_q));
    assign alloc_s  = push_s && !merge_s;
    assign st_ready = (!full || st_match_s) && (state_q == S_NORMAL);
`else
    assign alloc_s  = push_s;
    assign st_ready = !full && (state_q == S_NORMAL);
`endif

    assign count       = count_q;
    assign empty       = (count_q == CNT_W'(0));
    assign full        = (count_q == CNT_W'(DEPTH));
    assign push_s      = st_valid && st_ready;
    assign pop_s       = drain_valid && drain_ready;
    assign drain_valid = !empty && ((count_q >= CNT_W'(DRAIN_THRESH)) || (state_q == S_FLUSH) || ld_conflict);
    assign drain_addr  = addr_q[head_q];
    assign drain_data  = data_q[head_q];
    assign drain_be    = be_q[head_q];

    // Walk oldest to youngest so the last match is the youngest store.
    always_comb begin
        fwd_found_s = 1'b0;
        fwd_idx_s   = '0;
        fwd_sum_s   = '0;
        fwd_m_s     = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_sum_s   = {1'b0, head_q} + (PTR_W+1)'(k);
            fwd_sum_s   = (fwd_sum_s >= (PTR_W+1)'(DEPTH)) ? fwd_sum_s - (PTR_W+1)'(DEPTH) : fwd_sum_s;
            fwd_m_s     = valid_q[fwd_sum_s[PTR_W-1:0]] && (addr_q[fwd_sum_s[PTR_W-1:0]] == ld_addr);
            fwd_idx_s   = fwd_m_s ? fwd_sum_s[PTR_W-1:0] : fwd_idx_s;
            fwd_found_s = fwd_found_s | fwd_m_s;
        end
    end

    // Forwarding result: full byte coverage hits, partial coverage conflicts.
    always_comb begin
        ld_hit      = 1'b0;
        ld_conflict = 1'b0;
        ld_data     = '0;
        if (ld_valid && fwd_found_s) begin
            ld_data = data_q[fwd_idx_s];
            if ((be_q[fwd_idx_s] & ld_be) == ld_be) ld_hit = 1'b1;
            else                                    ld_conflict = 1'b1;
        end else begin
            ld_data = '0;
        end
    end

    // Pointer and occupancy next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_s) head_d = ptr_inc(head_q);
        else       head_d = head_q;
        if (alloc_s) tail_d = ptr_inc(tail_q);
        else         tail_d = tail_q;
        case ({alloc_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NORMAL/FLUSH sequencing; flush_done marks the FLUSH->NORMAL transition.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            S_NORMAL: begin
                if (flush) state_d = S_FLUSH;
                else       state_d = S_NORMAL;
            end
            S_FLUSH: begin
                if (count_q == CNT_W'(0)) begin
                    state_d    = S_NORMAL;
                    flush_done = 1'b1;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: state_d = S_NORMAL;
        endcase
    end

    // State, pointers and entry storage; allocation is written after pop so a shared slot ends valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_NORMAL;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop_s) valid_q[head_q] <= 1'b0;
            if (alloc_s) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= st_addr;
                data_q[tail_q]  <= st_data;
                be_q[tail_q]    <= st_be;
            end
`ifdef STORE_BUFFER_COALESCE_EN
            if (merge_s) begin
                data_q[st_match_idx_s] <= merge_bytes(data_q[st_match_idx_s], st_data, st_be);
                be_q[st_match_idx_s]   <= be_q[st_match_idx_s] | st_be;
            end
`endif
        end
    end
endmodule

// File: tb/tb_store_buffer_fifo.sv
// Self-checking bench for store_buffer_fifo: a queue model predicts drain order, occupancy and forwarding.
`timescale 1ns/1ps
module tb_store_buffer_fifo;
    localparam int DATA_W = 32, ADDR_W = 32, DEPTH = 4, DRAIN_THRESH = 2;
    localparam int BE_W = DATA_W / 8, CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } ent_t;

    logic clk = 1'b0;
    logic rst, st_valid, st_ready, ld_valid, ld_hit, ld_conflict;
    logic drain_valid, drain_ready, flush, flush_done, empty, full;
    logic [ADDR_W-1:0] st_addr, ld_addr, drain_addr;
    logic [DATA_W-1:0] st_data, ld_data, drain_data;
    logic [BE_W-1:0]   st_be, ld_be, drain_be;
    logic [CNT_W-1:0]  count;

    int errors = 0;
    int checks = 0;
    ent_t sb_q[$];

    store_buffer_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DRAIN_THRESH(DRAIN_THRESH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
        .drain_valid(drain_valid), .drain_ready(drain_ready),
        .drain_addr(drain_addr), .drain_data(drain_data), .drain_be(drain_be),
        .flush(flush), .flush_done(flush_done), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // One clock: scoreboard checks at the falling edge, then returns 1ns after the rising edge.
    task automatic tick();
        ent_t e;
        int fi;
        logic exp_hit, exp_conf, merged;
        logic [DATA_W-1:0] exp_ld;
        @(negedge clk);
        if (ld_valid) begin
            fi = -1;
            for (int i = 0; i < sb_q.size(); i++) if (sb_q[i].addr == ld_addr) fi = i;
            exp_hit = 1'b0; exp_conf = 1'b0; exp_ld = '0;
            if (fi >= 0) begin
                exp_ld = sb_q[fi].data;
                if ((sb_q[fi].be & ld_be) == ld_be) exp_hit = 1'b1;
                else exp_conf = 1'b1;
            end
            checks++;
            if ({ld_hit, ld_conflict, ld_data} !== {exp_hit, exp_conf, exp_ld}) begin
                errors++;
                $display("FAIL sb_forward addr=%h: hit/conf/data=%b/%b/%h expected %b/%b/%h",
                         ld_addr, ld_hit, ld_conflict, ld_data, exp_hit, exp_conf, exp_ld);
            end
        end
        checks++;
        if (count !== CNT_W'(sb_q.size())) begin
            errors++;
            $display("FAIL sb_count: got %0d expected %0d", count, sb_q.size());
        end
        if (drain_valid && drain_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_drain: pop of %h with nothing expected", drain_addr);
            end else begin
                e = sb_q.pop_front();
                if ({drain_addr, drain_data, drain_be} !== {e.addr, e.data, e.be}) begin
                    errors++;
                    $display("FAIL sb_drain: got %h/%h/%h expected %h/%h/%h",
                             drain_addr, drain_data, drain_be, e.addr, e.data, e.be);
                end
            end
        end
        if (st_valid && st_ready && !rst) begin
            merged = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
            for (int i = 0; i < sb_q.size(); i++) begin
                if (!merged && sb_q[i].addr == st_addr) begin
                    e = sb_q[i];
                    for (int b = 0; b < BE_W; b++) if (st_be[b]) e.data[8*b +: 8] = st_data[8*b +: 8];
                    e.be = e.be | st_be;
                    sb_q[i] = e;
                    merged = 1'b1;
                end
            end
`endif
            if (!merged) begin
                e.addr = st_addr; e.data = st_data; e.be = st_be;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain_all();
        logic done;
        drain_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; done = 1'b0;
        for (int c = 0; c < 3 * DEPTH + 4 && !done; c++) begin
            if (flush_done) done = 1'b1;
            else tick();
        end
        checks++;
        if (!done) begin errors++; $display("FAIL drain_all: flush_done timeout, got 0 expected 1"); end
        tick();
        drain_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_be = '0; drain_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({st_ready, drain_valid, ld_hit, ld_conflict, flush_done, empty, full} !== 7'b1000010) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 1000010",
                     {st_ready, drain_valid, ld_hit, ld_conflict, flush_done, empty, full});
        end
        checks++;
        if (count !== CNT_W'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if ({drain_addr, drain_data, drain_be, ld_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", drain_addr, drain_data, drain_be, ld_data);
        end
    endtask

    task automatic test_fill_drain();
        drain_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) store(32'h10 + i, 32'hD00D_0000 | i, 4'hF);
        checks++;
        if ({count, full, st_ready, drain_valid} !== {CNT_W'(4), 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fill: count/full/st_ready/drain_valid=%0d/%b/%b/%b expected 4/1/0/1",
                     count, full, st_ready, drain_valid);
        end
        checks++;
        if (drain_addr !== 32'h10) begin errors++; $display("FAIL fill_head: got %h expected 10", drain_addr); end
        drain_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({count, drain_valid} !== {CNT_W'(1), 1'b0}) begin
            errors++;
            $display("FAIL drain_thresh: count/drain_valid=%0d/%b expected 1/0", count, drain_valid);
        end
        drain_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic done, bad_ready;
        int n;
        store(32'h50, 32'h5050_5050, 4'hF);
        store(32'h51, 32'h5151_5151, 4'hF);
        checks++;
        if (count !== CNT_W'(3)) begin errors++; $display("FAIL flush_pre: count got %0d expected 3", count); end
        flush = 1'b1;
        tick();
        flush = 1'b0; drain_ready = 1'b1;
        done = 1'b0; bad_ready = 1'b0; n = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            if (flush_done) done = 1'b1;
            else begin
                if (drain_valid && drain_ready) n++;
                if (st_ready !== 1'b0) bad_ready = 1'b1;
                tick();
            end
        end
        checks++;
        if ({done, bad_ready} !== 2'b10 || n != 3) begin
            errors++;
            $display("FAIL flush_seq: done/bad_ready/drains=%b/%b/%0d expected 1/0/3", done, bad_ready, n);
        end
        tick();
        checks++;
        if ({flush_done, st_ready, empty} !== 3'b011) begin
            errors++;
            $display("FAIL flush_exit: flush_done/st_ready/empty=%b expected 011", {flush_done, st_ready, empty});
        end
        drain_ready = 1'b0;
    endtask

    task automatic test_forward();
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'hAABB_CCDD; st_be = 4'hF;
        ld_valid = 1'b1; ld_addr = 32'h20; ld_be = 4'hF;
        #1;
        checks++;
        if ({ld_hit, ld_conflict} !== 2'b00) begin
            errors++; $display("FAIL fwd_same_cycle: hit/conf=%b%b expected 00", ld_hit, ld_conflict);
        end
        tick();
        st_valid = 1'b0; ld_be = 4'h3;
        #1;
        checks++;
        if ({ld_hit, ld_conflict, ld_data} !== {2'b10, 32'hAABB_CCDD}) begin
            errors++; $display("FAIL fwd_hit: %b%b/%h expected 10/aabbccdd", ld_hit, ld_conflict, ld_data);
        end
        ld_be = 4'h0;
        #1;
        checks++;
        if (ld_hit !== 1'b1) begin errors++; $display("FAIL fwd_be0: hit got %b expected 1", ld_hit); end
        ld_valid = 1'b0;
        #1;
        checks++;
        if ({ld_hit, ld_conflict, ld_data} !== '0) begin
            errors++; $display("FAIL fwd_idle: %b%b/%h expected zeros", ld_hit, ld_conflict, ld_data);
        end
        store(32'h20, 32'h1122_3344, 4'hF);
        ld_valid = 1'b1; ld_be = 4'hF;
        #1;
        checks++;
        if ({ld_hit, ld_data} !== {1'b1, 32'h1122_3344}) begin
            errors++; $display("FAIL fwd_youngest: %b/%h expected 1/11223344", ld_hit, ld_data);
        end
        ld_addr = 32'h99;
        #1;
        checks++;
        if ({ld_hit, ld_conflict, ld_data} !== '0) begin
            errors++; $display("FAIL fwd_miss: %b%b/%h expected zeros", ld_hit, ld_conflict, ld_data);
        end
        tick();
        ld_valid = 1'b0;
        drain_all();
    endtask

    task automatic test_conflict();
        store(32'h30, 32'h0000_00EE, 4'h1);
        ld_valid = 1'b1; ld_addr = 32'h30; ld_be = 4'h3;
        #1;
        checks++;
        if ({ld_conflict, ld_hit, drain_valid} !== 3'b101) begin
            errors++; $display("FAIL conflict: conf/hit/drain_valid=%b expected 101", {ld_conflict, ld_hit, drain_valid});
        end
        ld_valid = 1'b0;
        #1;
        checks++;
        if (drain_valid !== 1'b0) begin errors++; $display("FAIL conflict_idle: drain_valid got %b expected 0", drain_valid); end
        ld_valid = 1'b1; drain_ready = 1'b1;
        tick();
        ld_valid = 1'b0; drain_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL conflict_drain: empty got %b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic bad;
        bad = 1'b0;
        drain_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            st_valid = 1'b1; st_addr = 32'h60 + i; st_data = $urandom; st_be = 4'hF;
            if (st_ready !== 1'b1) bad = 1'b1;
            tick();
            if (count > CNT_W'(2)) bad = 1'b1;
        end
        st_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bad, count} !== {1'b0, CNT_W'(1)}) begin
            errors++; $display("FAIL back_to_back: stall/count=%b/%0d expected 0/1", bad, count);
        end
        drain_all();
    endtask

    task automatic test_coalesce();
        logic [CNT_W-1:0] exp_cnt;
        logic [BE_W-1:0]  exp_be;
        logic [15:0]      exp_lo;
`ifdef STORE_BUFFER_COALESCE_EN
        exp_cnt = CNT_W'(1); exp_be = 4'h3; exp_lo = 16'h2211;
`else
        exp_cnt = CNT_W'(2); exp_be = 4'h1; exp_lo = 16'h0011;
`endif
        store(32'h40, 32'h0000_0011, 4'h1);
        store(32'h40, 32'h0000_2200, 4'h2);
        checks++;
        if ({count, drain_be, drain_data[15:0]} !== {exp_cnt, exp_be, exp_lo}) begin
            errors++;
            $display("FAIL coalesce: count/be/data=%0d/%h/%h expected %0d/%h/%h",
                     count, drain_be, drain_data[15:0], exp_cnt, exp_be, exp_lo);
        end
        drain_all();
    endtask

    task automatic test_reset_mid_flush();
        logic seen;
        store(32'h70, 32'h7070_7070, 4'hF);
        store(32'h71, 32'h7171_7171, 4'hF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({count, empty, drain_valid} !== {CNT_W'(0), 1'b1, 1'b0}) begin
            errors++; $display("FAIL rst_flush: count/empty/drain_valid=%0d/%b/%b expected 0/1/0", count, empty, drain_valid);
        end
        sb_q.delete();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (flush_done) seen = 1'b1;
            tick();
        end
        checks++;
        if ({seen, st_ready} !== 2'b01) begin
            errors++; $display("FAIL rst_flush_after: flush_done_seen/st_ready=%b%b expected 01", seen, st_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_flush();
        test_forward();
        test_conflict();
        test_back_to_back();
        test_coalesce();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/store_buffer_fifo.md
# store_buffer_fifo

Parametrised, in-order store buffer between the memory stage and the data cache. Accepts byte-masked stores, holds up to DEPTH entries, drains the oldest entry to the cache over a valid/ready handshake, and forwards store data to younger loads. Replaces the single-width store buffer with configurable depth, width, drain threshold, explicit flush and optional store coalescing.

## Interface
Parameters:
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 32, word-address width; compared at full width
- DEPTH, 4, number of entries; ≥2
- DRAIN_THRESH, 1, minimum occupancy before eager draining; 1..DEPTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- st_valid  in  1  store request
- st_ready  out  1  store accepted when st_valid && st_ready at posedge
- st_addr  in  ADDR_W  store word address
- st_data  in  DATA_W  store data
- st_be  in  DATA_W/8  store byte enables
- ld_valid  in  1  load lookup request
- ld_addr  in  ADDR_W  load word address
- ld_be  in  DATA_W/8  bytes requested
- ld_hit  out  1  forwarding success
- ld_data  out  DATA_W  forwarded data
- ld_conflict  out  1  partial match; core must stall the load
- drain_valid  out  1  head entry offered to cache
- drain_ready  in  1  cache accepts head
- drain_addr  out  ADDR_W  head address
- drain_data  out  DATA_W  head data
- drain_be  out  DATA_W/8  head byte enables
- flush  in  1  request full drain
- flush_done  out  1  one-cycle pulse when flush completes
- count  out  $clog2(DEPTH+1)  occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Circular FIFO: head/tail pointers wrap modulo DEPTH; per-entry valid, addr, data, be.
- FSM NORMAL / FLUSH. NORMAL→FLUSH on flush=1. FLUSH→NORMAL the cycle after count reaches 0, with flush_done=1 for exactly that transition cycle. flush while already empty: FLUSH for one cycle, then flush_done.
- st_ready = !full && state==NORMAL.
- drain_valid = !empty && (count ≥ DRAIN_THRESH || state==FLUSH || ld_conflict). Pop on drain_valid && drain_ready.
- Push and pop in same cycle: both occur, count unchanged. Push when full impossible (st_ready=0); a pop on a full cycle does not raise st_ready until the next cycle.
- Forwarding: among valid entries with addr==ld_addr, select the youngest. ld_hit=1 if (sel.be & ld_be)==ld_be; ld_data=sel.data. If a match exists but coverage is incomplete, ld_conflict=1, ld_hit=0. No match: both 0. ld_be==0 with a match counts as hit. All forwarding outputs are 0 when ld_valid=0.
- A store accepted in cycle N is not visible to forwarding in cycle N.
- Reset (any cycle, including mid-drain or mid-flush): all entries invalidated, pointers and count 0, state NORMAL.

## Timing
- Reset values: st_ready=1, drain_valid=0, ld_hit=0, ld_conflict=0, flush_done=0, count=0, empty=1, full=0, drain_* and ld_data=0.
- Store latency: entry visible to forwarding and drain one cycle after acceptance.
- Forwarding: combinational, same cycle as ld_valid.
- drain_* are driven from registers (head entry); stable while drain_valid && !drain_ready.
- Back-to-back: one push and one pop per cycle sustained.

## Configuration
- STORE_BUFFER_COALESCE_EN defined: an accepted store whose address matches a valid entry merges into it (bytes with st_be set overwrite data; be |= st_be); count unchanged; accepted even when full if a merge target exists (st_ready = (!full || match) && NORMAL). If the match is the head popping that cycle, a new entry is allocated instead. Invariant: at most one entry per address.
- Not defined: every accepted store allocates a new entry; duplicate addresses allowed; forwarding uses the youngest.

## Test plan
- Reset, then 4 stores to 0x10..0x13 with drain_ready=0, DEPTH=4 -> count=4, full=1, st_ready=0; raise drain_ready -> drains 0x10,0x11,0x12,0x13 in order, one per cycle.
- Store 0x20 data 0xAABBCCDD be=0xF; next cycle load 0x20 be=0x3 -> ld_hit=1, ld_data=0xAABBCCDD.
- Store 0x30 be=0x1; load 0x30 be=0x3 -> ld_conflict=1, drain_valid=1 even with DRAIN_THRESH=4.
- 3 entries, drain_ready=1, flush=1 -> st_ready=0 for 3 drain cycles, flush_done pulses once, then NORMAL, st_ready=1.
- COALESCE_EN: store 0x40 be=0x1 data 0x11, then 0x40 be=0x2 data 0x2200 -> count=1, drain_be=0x3, drain_data low half 0x2211; without macro count=2.
- Assert rst mid-flush with 2 entries -> next cycle count=0, empty=1, drain_valid=0, flush_done never pulses.
